// File: rtl/wt_mem_req_sched.sv
// Arbitrates icache reads, dcache reads and write-buffer stores onto one memory request channel.
// Latency: one cycle from a granted request to mem_valid_o; at most one request per two cycles.
// Backpressure: mem_* is held while mem_ready_i is low; stores stall at the outstanding limit, fences block all ports.
module wt_mem_req_sched #(
   parameter int unsigned PLEN                 = 34,
   parameter int unsigned DataWidth            = 64,
   parameter int unsigned TidWidth             = 2,
   parameter int unsigned MaxOutstandingStores = 7
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [2:0]                req_valid_i,
   output logic [2:0]                req_ready_o,
   input  logic [3*PLEN-1:0]         req_addr_i,
   input  logic [3*TidWidth-1:0]     req_tid_i,
   input  logic                      req_nonidem_i,
   input  logic [DataWidth-1:0]      st_data_i,
   input  logic [DataWidth/8-1:0]    st_be_i,
   output logic                      mem_valid_o,
   input  logic                      mem_ready_i,
   output logic [1:0]                mem_src_o,
   output logic                      mem_write_o,
   output logic [PLEN-1:0]           mem_addr_o,
   output logic [TidWidth-1:0]       mem_tid_o,
   output logic [DataWidth-1:0]      mem_data_o,
   output logic [DataWidth/8-1:0]    mem_be_o,
   input  logic                      st_ack_i,
   input  logic                      fence_i,
   output logic                      fence_done_o,
   output logic [2:0]                st_cnt_o,
   output logic                      ack_err_o
);

   localparam logic [2:0] MaxCnt = 3'(MaxOutstandingStores);

   // Everything the bus adapter sees for one request, captured at grant time.
   typedef struct packed {
      logic [1:0]             src;
      logic                   write;
      logic [PLEN-1:0]        addr;
      logic [TidWidth-1:0]    tid;
      logic [DataWidth-1:0]   data;
      logic [DataWidth/8-1:0] be;
   } hdr_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HOLD  = 2'd1,
      S_FENCE = 2'd2
   } state_t;

   state_t     r_state;
   hdr_t       r_hdr;
   logic       r_mem_valid;
   logic [1:0] r_rr;
   logic       r_fence_pend;
   logic       r_fence_done;
   logic [2:0] r_cnt;
   logic       r_ack_err;

   logic [2:0] w_elig;
   logic [2:0] w_cand;
   logic       w_gnt_vld;
   logic [1:0] w_gnt_idx;
   logic       w_gnt_ok;
   hdr_t       w_hdr_nxt;
   logic       w_hs;
   logic       w_st_inc;

   // Port index p+k reduced modulo 3 (p, k both in 0..2).
   function automatic logic [1:0] f_wrap(input logic [1:0] p, input logic [1:0] k);
      logic [2:0] s;
      s = {1'b0, p} + {1'b0, k};
      if (s >= 3'd3) begin
         s = s - 3'd3;
      end
      return s[1:0];
   endfunction

   // Eligibility gating and round-robin pick starting at the pointer.
   always_comb begin
      w_elig    = 3'b000;
      w_elig[0] = 1'b1;
      // A non-idempotent read must not overtake any store, issued or waiting.
      w_elig[1] = !req_nonidem_i || ((r_cnt == 3'd0) && !req_valid_i[2]);
      w_elig[2] = (r_cnt < MaxCnt);
      w_cand    = req_valid_i & w_elig;
      w_gnt_vld = 1'b0;
      w_gnt_idx = 2'd0;
      for (int k = 0; k < 3; k++) begin
         if (!w_gnt_vld && w_cand[f_wrap(r_rr, 2'(k))]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = f_wrap(r_rr, 2'(k));
         end
      end
      // A fence arriving in IDLE takes priority over any request that cycle.
      w_gnt_ok = (r_state == S_IDLE) && !fence_i && !rst_i && w_gnt_vld;
   end

   // Gather the granted port's fields; only the store port carries data.
   always_comb begin
      w_hdr_nxt       = '0;
      w_hdr_nxt.src   = w_gnt_idx;
      w_hdr_nxt.write = (w_gnt_idx == 2'd2);
      case (w_gnt_idx)
         2'd1: begin
            w_hdr_nxt.addr = req_addr_i[PLEN +: PLEN];
            w_hdr_nxt.tid  = req_tid_i[TidWidth +: TidWidth];
         end
         2'd2: begin
            w_hdr_nxt.addr = req_addr_i[2*PLEN +: PLEN];
            w_hdr_nxt.tid  = req_tid_i[2*TidWidth +: TidWidth];
            w_hdr_nxt.data = st_data_i;
            w_hdr_nxt.be   = st_be_i;
         end
         default: begin
            w_hdr_nxt.addr = req_addr_i[0 +: PLEN];
            w_hdr_nxt.tid  = req_tid_i[0 +: TidWidth];
         end
      endcase
   end

   assign req_ready_o = w_gnt_ok ? (3'b001 << w_gnt_idx) : 3'b000;
   assign w_hs        = (r_state == S_HOLD) && mem_ready_i;
   assign w_st_inc    = w_hs && r_hdr.write;

   // Grant / hold / fence sequencer with registered request and fence outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_hdr        <= '0;
         r_mem_valid  <= 1'b0;
         r_rr         <= 2'd0;
         r_fence_pend <= 1'b0;
         r_fence_done <= 1'b0;
      end else begin
         r_fence_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (fence_i) begin
                  r_state <= S_FENCE;
               end else if (w_gnt_ok) begin
                  r_hdr       <= w_hdr_nxt;
                  r_mem_valid <= 1'b1;
                  r_rr        <= f_wrap(w_gnt_idx, 2'd1);
                  r_state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (fence_i) begin
                  r_fence_pend <= 1'b1;
               end
               if (mem_ready_i) begin
                  r_mem_valid <= 1'b0;
                  if (r_fence_pend || fence_i) begin
                     r_fence_pend <= 1'b0;
                     r_state      <= S_FENCE;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_FENCE: begin
               if (r_cnt == 3'd0) begin
                  r_fence_done <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Outstanding-store counter and sticky underflow flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt     <= 3'd0;
         r_ack_err <= 1'b0;
      end else begin
         if (st_ack_i && (r_cnt == 3'd0)) begin
            r_ack_err <= 1'b1;
         end
         case ({w_st_inc, st_ack_i})
            2'b10: r_cnt <= r_cnt + 3'd1;
            2'b01: begin
               if (r_cnt != 3'd0) begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   assign mem_valid_o  = r_mem_valid;
   assign mem_src_o    = r_hdr.src;
   assign mem_write_o  = r_hdr.write;
   assign mem_addr_o   = r_hdr.addr;
   assign mem_tid_o    = r_hdr.tid;
   assign mem_data_o   = r_hdr.data;
   assign mem_be_o     = r_hdr.be;
   assign fence_done_o = r_fence_done;
   assign st_cnt_o     = r_cnt;
   assign ack_err_o    = r_ack_err;

endmodule
